// File: rtl/rom_osc_pkg.sv
// Shared oscillator constants and quadrature table generator, used by the
// demodulator and the cos oscillator so both see bit-identical tables.
package rom_osc_pkg;

    localparam real PI = 3.14159265358979323846;

    function automatic int width_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // entry = trunc(f(2*pi*idx/n) * (2^width/2 - 1)), truncated toward zero
    function automatic int quad_entry(input int width, input int n, input int idx, input bit is_sin);
        real amp;
        real ang;
        amp = real'((longint'(1) << (width - 1)) - longint'(1));
        ang = 2.0 * PI * real'(idx) / real'(n);
        return is_sin ? $rtoi($sin(ang) * amp) : $rtoi($cos(ang) * amp);
    endfunction

endpackage

// File: rtl/rom_quadrature_lut.sv
// Cos/sin reference tables with a registered lookup (1-cycle latency).
module rom_quadrature_lut
    import rom_osc_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int N      = 5,
    parameter int PTR_W  = 3
)(
    input  logic              clk,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [DATA_W-1:0] o_cos,
    output logic [DATA_W-1:0] o_sin
);

    logic [DATA_W-1:0] w_cos_tab [N];
    logic [DATA_W-1:0] w_sin_tab [N];
    logic [DATA_W-1:0] r_cos;
    logic [DATA_W-1:0] r_sin;

    for (genvar g = 0; g < N; g++) begin : g_tab
        assign w_cos_tab[g] = DATA_W'(quad_entry(DATA_W, N, g, 1'b0));
        assign w_sin_tab[g] = DATA_W'(quad_entry(DATA_W, N, g, 1'b1));
    end

    always_ff @(posedge clk) begin
        r_cos <= w_cos_tab[i_ptr];
        r_sin <= w_sin_tab[i_ptr];
    end

    assign o_cos = r_cos;
    assign o_sin = r_sin;

endmodule

// File: rtl/lockin_demodulator.sv
// Lock-in I/Q demodulator: multiplies samples by cos/sin references and
// integrates over windows of K samples, emitting one I/Q result per window.
module lockin_demodulator
    import rom_osc_pkg::*;
#(
    parameter int  INT_DATA_WIDTH    = 20,
    parameter real REAL_IN_FREQ_MHZ  = 125.0,
    parameter real REAL_OUT_FREQ_MHZ = 25.0,
    parameter int  INT_ACC_PERIODS   = 16,
    localparam int N     = $rtoi(REAL_IN_FREQ_MHZ / REAL_OUT_FREQ_MHZ),
    localparam int K     = N * INT_ACC_PERIODS,
    localparam int ACC_W = 2 * INT_DATA_WIDTH + $clog2(K)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [INT_DATA_WIDTH-1:0] i_data,
    input  logic                      i_sync,
    output logic                      o_valid,
    output logic [ACC_W-1:0]          o_i,
    output logic [ACC_W-1:0]          o_q
);

    localparam int PTR_W  = width_for(N);
    localparam int CNT_W  = width_for(K);
    localparam int PROD_W = 2 * INT_DATA_WIDTH;

    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_ptr_cur;
    logic [CNT_W-1:0] w_cnt_cur;
    logic             w_first;
    logic             w_last;

    // i_sync takes effect in its own cycle so a coincident sample lands at phase 0
    always_comb begin
        w_ptr_cur = i_sync ? '0 : r_ptr;
        w_cnt_cur = i_sync ? '0 : r_cnt;
        w_first   = (w_cnt_cur == '0);
        w_last    = (w_cnt_cur == CNT_W'(K - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_valid) begin
            r_ptr <= (w_ptr_cur == PTR_W'(N - 1)) ? '0 : w_ptr_cur + 1'b1;
            r_cnt <= w_last ? '0 : w_cnt_cur + 1'b1;
        end else if (i_sync) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end
    end

    logic [INT_DATA_WIDTH-1:0] w_cos;
    logic [INT_DATA_WIDTH-1:0] w_sin;

    rom_quadrature_lut #(
        .DATA_W (INT_DATA_WIDTH),
        .N      (N),
        .PTR_W  (PTR_W)
    ) u_lut (
        .clk    (clk),
        .i_ptr  (w_ptr_cur),
        .o_cos  (w_cos),
        .o_sin  (w_sin)
    );

    // stage 1: sample aligned with the registered table outputs
    logic                             r_s1_vld;
    logic                             r_s1_first;
    logic                             r_s1_last;
    logic signed [INT_DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_vld   <= i_valid;
            r_s1_first <= w_first;
            r_s1_last  <= w_last;
            r_s1_data  <= $signed(i_data);
        end
    end

    // stage 2: full-precision products
    logic                     r_s2_vld;
    logic                     r_s2_first;
    logic                     r_s2_last;
    logic signed [PROD_W-1:0] r_s2_pi;
    logic signed [PROD_W-1:0] r_s2_pq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld   <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_pi    <= '0;
            r_s2_pq    <= '0;
        end else begin
            r_s2_vld   <= r_s1_vld & ~i_sync;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_pi    <= PROD_W'(r_s1_data) * PROD_W'($signed(w_cos));
            r_s2_pq    <= PROD_W'(r_s1_data) * PROD_W'($signed(w_sin));
        end
    end

    // stage 3: accumulate; the first sample of a window reloads instead of adding
    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic signed [ACC_W-1:0] w_acc_i_nxt;
    logic signed [ACC_W-1:0] w_acc_q_nxt;
    logic                    r_o_valid;
    logic [ACC_W-1:0]        r_o_i;
    logic [ACC_W-1:0]        r_o_q;

    always_comb begin
        w_acc_i_nxt = r_s2_first ? ACC_W'(r_s2_pi) : r_acc_i + ACC_W'(r_s2_pi);
        w_acc_q_nxt = r_s2_first ? ACC_W'(r_s2_pq) : r_acc_q + ACC_W'(r_s2_pq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            r_o_valid <= 1'b0;
            r_o_i     <= '0;
            r_o_q     <= '0;
        end else begin
            r_o_valid <= r_s2_vld & r_s2_last & ~i_sync;
            if (i_sync) begin
                r_acc_i <= '0;
                r_acc_q <= '0;
            end else if (r_s2_vld) begin
                r_acc_i <= w_acc_i_nxt;
                r_acc_q <= w_acc_q_nxt;
                if (r_s2_last) begin
                    r_o_i <= w_acc_i_nxt;
                    r_o_q <= w_acc_q_nxt;
                end
            end
        end
    end

    assign o_valid = r_o_valid;
    assign o_i     = r_o_i;
    assign o_q     = r_o_q;

endmodule

// File: tb/tb_lockin_demodulator.sv
// Randomized scoreboard bench: window sums are modelled as plain sums of
// sample*reference over accepted samples, and checked when o_valid fires.
module tb_lockin_demodulator;

    localparam int  W     = 20;
    localparam int  N     = 5;
    localparam int  K     = 80;
    localparam int  ACC_W = 47;
    localparam real PI    = 3.14159265358979323846;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_sync = 1'b0;
    logic [W-1:0]     i_data = '0;
    logic             o_valid;
    logic [ACC_W-1:0] o_i;
    logic [ACC_W-1:0] o_q;

    lockin_demodulator dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_sync  (i_sync),
        .o_valid (o_valid),
        .o_i     (o_i),
        .o_q     (o_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint ei;
        longint eq;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    bit     mon_en = 1'b0;
    longint hold_i = 0;
    longint hold_q = 0;
    int     cos_t[N];
    int     sin_t[N];
    longint m_i = 0;
    longint m_q = 0;
    int     m_cnt = 0;

    // reset zeroes the result registers, so the held value becomes 0
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            hold_i = 0;
            hold_q = 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            longint ai;
            longint aq;
            exp_t   e;
            ai = longint'($signed(o_i));
            aq = longint'($signed(o_q));
            checks++;
            if (o_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_o_valid cyc=%0d o_i=%0d o_q=%0d required=no_output", cyc, ai, aq);
                end else begin
                    e = sb.pop_front();
                    if (ai != e.ei || aq != e.eq || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL window_result got i=%0d q=%0d cyc=%0d required i=%0d q=%0d cyc=%0d",
                                 ai, aq, cyc, e.ei, e.eq, e.cyc);
                    end
                    hold_i = e.ei;
                    hold_q = e.eq;
                end
            end else if (o_valid !== 1'b0 || ai != hold_i || aq != hold_q) begin
                failures++;
                $display("FAIL hold cyc=%0d got v=%b i=%0d q=%0d required v=0 i=%0d q=%0d",
                         cyc, o_valid, ai, aq, hold_i, hold_q);
            end
        end
    end

    task automatic step(input bit v, input int d, input bit s, input bit r);
        int p;
        @(negedge clk);
        i_valid = v;
        i_data  = W'(d);
        i_sync  = s;
        rst     = r;
        if (r || s) begin
            // results not yet visible are lost with the discarded pipeline
            while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
            m_cnt = 0;
            m_i   = 0;
            m_q   = 0;
        end
        if (v && !r) begin
            p = m_cnt % N;
            m_i += longint'(d) * longint'(cos_t[p]);
            m_q += longint'(d) * longint'(sin_t[p]);
            m_cnt++;
            if (m_cnt == K) begin
                sb.push_back('{m_i, m_q, cyc + 3});
                m_cnt = 0;
                m_i   = 0;
                m_q   = 0;
            end
        end
    endtask

    function automatic int rnd_data();
        return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
    endfunction

    initial begin
        real amp;
        amp = real'((1 << (W - 1)) - 1);
        for (int i = 0; i < N; i++) begin
            cos_t[i] = $rtoi($cos(real'(i) * 360.0 / real'(N) * PI / 180.0) * amp);
            sin_t[i] = $rtoi($sin(real'(i) * 360.0 / real'(N) * PI / 180.0) * amp);
        end

        repeat (3) step(0, 0, 0, 1);
        mon_en = 1'b1;
        step(0, 0, 0, 0);

        // zero, constant, reference-matched (two back-to-back windows)
        for (int n = 0; n < K; n++) step(1, 0, 0, 0);
        for (int n = 0; n < K; n++) step(1, 1000, 0, 0);
        for (int n = 0; n < 2 * K; n++) step(1, cos_t[n % N], 0, 0);

        // gapped: one valid in three cycles
        for (int n = 0; n < 3 * K; n++) step(n % 3 == 0, cos_t[(n / 3) % N], 0, 0);

        // random data with random valid gaps
        for (int n = 0; n < 4 * K; n++) step($urandom_range(0, 3) != 0, rnd_data(), 0, 0);

        // fresh window, then sync+valid at sample 37 restarts it
        step(1, rnd_data(), 1, 0);
        for (int n = 1; n < 36; n++) step(1, rnd_data(), 0, 0);
        step(1, rnd_data(), 1, 0);
        for (int n = 1; n < K; n++) step(1, rnd_data(), 0, 0);

        // sync right behind the last sample kills that window's result
        for (int n = 0; n < K; n++) step(1, rnd_data(), 0, 0);
        step(0, 0, 1, 0);

        // reset at sample 37, then a full-scale window
        for (int n = 0; n < 36; n++) step(1, rnd_data(), 0, 0);
        step(1, rnd_data(), 0, 1);
        step(0, 0, 0, 1);
        for (int n = 0; n < K; n++) step(1, (n % 2 == 0) ? -(1 << (W - 1)) : (1 << (W - 1)) - 1, 0, 0);

        // reset two cycles after a window's last sample drops its result
        for (int n = 0; n < K; n++) step(1, rnd_data(), 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int n = 0; n < 12; n++) step(0, 0, 0, 0);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lockin_demodulator.md
LOCKIN_DEMODULATOR -- requirements
Module: lockin_demodulator

Interface
REQ-001 SHALL have parameter INT_DATA_WIDTH, default 20, giving the width of the input sample and of each reference table entry.
REQ-002 SHALL have parameter REAL_IN_FREQ_MHZ, default 125.0, the sample rate.
REQ-003 SHALL have parameter REAL_OUT_FREQ_MHZ, default 25.0, the reference frequency; N = $rtoi(REAL_IN_FREQ_MHZ/REAL_OUT_FREQ_MHZ) samples per period (5 at defaults).
REQ-004 SHALL have parameter INT_ACC_PERIODS, default 16, the periods per integration window; K = N*INT_ACC_PERIODS samples.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports: clk  in  1  sole clock, rising edge.
REQ-007 Ports: rst  in  1  synchronous active-high reset.
REQ-008 Ports: i_valid  in  1  i_data is valid this cycle.
REQ-009 Ports: i_data  in  INT_DATA_WIDTH  signed input sample.
REQ-010 Ports: i_sync  in  1  one-cycle pulse; restarts phase and window.
REQ-011 Ports: o_valid  out  1  one-cycle pulse; o_i/o_q hold a new result.
REQ-012 Ports: o_i  out  ACC_W  signed in-phase sum; ACC_W = 2*INT_DATA_WIDTH + $clog2(K).
REQ-013 Ports: o_q  out  ACC_W  signed quadrature sum.

Function
REQ-014 SHALL hold cos and sin tables of N entries: entry[i] = $rtoi(f(i*360.0/N degrees)*(2^INT_DATA_WIDTH/2 - 1)), truncated toward zero.
- f is cos for the cos table and sin for the sin table.
REQ-015 SHALL advance the phase pointer by one, modulo N, only on cycles with i_valid=1; without i_valid the pointer holds.
REQ-016 Stage 1 SHALL register the sample together with cos[ptr] and sin[ptr] read at the current pointer.
REQ-017 Stage 2 SHALL register both full-precision 2*INT_DATA_WIDTH signed products, with no rounding and no truncation.
REQ-018 Stage 3 SHALL sign-extend the products to ACC_W and add them into the I/Q accumulators.
REQ-019 SHALL count accepted samples. When the K-th sample of a window reaches stage 3, o_i/o_q SHALL load the complete sums including that sample.
- o_valid is high exactly 3 cycles after the cycle in which the K-th i_valid was high.
REQ-020 The next window SHALL start with sample K+1 with no dead cycle: the accumulators load that sample's product rather than adding to the old sum.
REQ-021 o_i and o_q SHALL hold their value between o_valid pulses.
REQ-022 i_sync SHALL set the pointer and sample count to 0, clear the accumulators, and discard in-flight pipeline samples. The partial window produces no o_valid.
REQ-023 If i_sync and i_valid occur in the same cycle, that sample SHALL be sample 1 of the new window, at phase 0.
REQ-024 The design SHALL be fully pipelined: it accepts i_valid on every cycle, with no backpressure.
REQ-025 A sample in flight in stages 1-3 when i_sync arrives SHALL NOT be accumulated into the new window.

Reset
REQ-026 On rst=1: pointer, sample count, pipeline valids and accumulators SHALL be 0; o_valid, o_i and o_q SHALL be 0 on the following cycle.
REQ-027 rst SHALL have priority over i_sync and i_valid. Reset mid-window discards the window, and in-flight samples produce no output.

Structure
REQ-028 The PI constant and a table-generation function taking (INT_DATA_WIDTH, N, cos/sin select) SHALL live in a shared package rom_osc_pkg, so the demodulator and the cos oscillator share identical tables.
REQ-029 Table storage and the registered lookup SHALL be one sub-module, rom_quadrature_lut (inputs: pointer; outputs: cos and sin, 1-cycle latency).
REQ-030 The accumulators and the window counter SHALL stay in the top module.

Verification
REQ-031 Zero input test: i_data=0, i_valid=1 for K=80 cycles. One o_valid SHALL occur 3 cycles after the last sample, with o_i=0 and o_q=0.
REQ-032 Constant input test: i_data=1000 for K cycles. Results SHALL be o_i = 16*1000*sum(cos table) and o_q = 16*1000*sum(sin table), matching the golden model bit-exactly.
REQ-033 Reference-matched input test: feed i_data = cos table[n mod 5]. o_i SHALL equal 16*sum(cos^2 entries) and o_q SHALL equal 16*sum(cos*sin entries), bit-exact.
- Then apply back-to-back windows: consecutive o_valid pulses SHALL be exactly 80 cycles apart.
REQ-034 Gapped valid test: i_valid is high in 1 cycle of 3 over 240 cycles. The results SHALL equal the ungapped case, and o_valid SHALL follow the 80th accepted sample by 3 cycles.
REQ-035 Mid-window sync and reset test: pulse i_sync together with i_valid at sample 37. There SHALL be no o_valid for the old window, and the next o_valid comes 80 samples later with phase restarted at 0.
- Repeat with rst at sample 37: outputs read 0 and no stale o_valid occurs.
